fifo_flops_reader: RTL and testbench
====================================

Name: fifo_flops_reader

Overview:
- Read-side consumer for fifo_flops.
- Monitors pndng, samples Dout, generates pop, and re-presents the words on a valid/ready stream toward downstream logic.
- A 2-entry output buffer sustains 1 word/cycle while keeping pop free of any combinational path from the downstream ready.
- Also counts words drained, for scoreboard cross-checks in the FIFO environment.

Parameters:
- bits, 16, data width; must equal the bits value of the attached fifo_flops.
- cnt_w, 16, width of the rd_count word counter.

Ports:
- clk  input  1  single clock; every register updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pndng  input  1  fifo_flops not-empty flag.
- fifo_dout  input  bits  fifo_flops Dout; FIFO head word, valid whenever pndng=1.
- pop  output  1  pop strobe to fifo_flops; the head is consumed on the edge where pop=1.
- enable  input  1  drain enable; 0 stops new pops only.
- out_data  output  bits  buffer head word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the word this cycle.
- rd_count  output  cnt_w  number of pops since reset, modulo 2^cnt_w.

Behaviour:
- fifo_flops is first-word-fall-through: while pndng=1, fifo_dout holds the head word. No read latency.
- pop = !rst && enable && pndng && (occ != TWO). This is combinational from registered occ and the inputs only. There is no path from out_ready to pop.
- Capture: on an edge with pop=1, fifo_dout is written into the buffer tail the same cycle. Capture latency is 0; out_valid rises the cycle after the pop edge.
- Fire = out_valid && out_ready; on a fire edge the head entry is removed.
- Occupancy FSM, states EMPTY/ONE/TWO:
  - EMPTY: pop -> ONE; otherwise stay.
  - ONE: pop and no fire -> TWO; fire and no pop -> EMPTY; pop and fire -> ONE, new word becomes head; neither -> stay.
  - TWO: pop is forced 0; fire -> ONE, second entry shifts to head; otherwise stay.
- out_valid = (occ != EMPTY). out_data = head entry.
- out_data and out_valid hold stable while out_valid=1 and out_ready=0.
- Order: words leave strictly in FIFO order; no drop, no duplication.
- rd_count increments by 1 on every pop edge and wraps 2^cnt_w-1 -> 0 silently.
- Reset values, applied on any edge with rst=1: occ=EMPTY, out_valid=0, out_data=0, both buffer entries=0, rd_count=0. pop=0 while rst=1.
- Reset mid-operation: buffered words are discarded. Words still in fifo_flops are not popped during reset; fifo_flops is normally reset by the same rst.
- enable=0: pop=0 the same cycle. Buffered words still drain to out_ready. rd_count freezes.
- pndng=0 with a free buffer slot: pop=0, and fifo_dout is ignored.
- Full throughput: with out_ready held 1 and pndng held 1, occ stays ONE and one word passes per cycle.
- Backpressure: out_ready=0 lets at most 2 words be popped, then pop stays 0 until a fire.
- Simultaneous pop and fire in state ONE is legal and must not lose the incoming word.

Decomposition:
- Shared package fifo_rd_pkg:
  - enum occ_t {EMPTY, ONE, TWO};
  - localparam OCC_W = 2;
  - typedef for the word type, parameterised by bits via the module.
- Natural sub-module: fifo_rd_skid, holding the 2-entry buffer and occupancy FSM (push/data in, valid/ready out, space flag).
- The top level adds pop generation and rd_count.

Test Plan:
- Reset and idle: rst=1 for 3 cycles, pndng=0 -> pop=0, out_valid=0, out_data=0, rd_count=0. Release rst -> all outputs remain idle.
- Streaming: push 0x0001..0x0008 into fifo_flops (depth 8), enable=1, out_ready=1 -> pop high 8 consecutive cycles. out_data delivers 0x0001..0x0008 in order, one per cycle. rd_count=8. pndng=0 afterwards.
- Backpressure: FIFO holds 0xA5A5, 0x5A5A, 0xFFFF, out_ready=0 -> exactly 2 pops, then pop=0 with occ=TWO and out_data held at 0xA5A5. Raise out_ready -> 0x5A5A then 0xFFFF follow, rd_count=3.
- Enable gating: enable=0 with 4 words in the FIFO -> no pops and rd_count unchanged. Words buffered before enable fell still drain. Set enable=1 -> draining resumes in order.
- Reset mid-stream: assert rst with occ=TWO -> next cycle out_valid=0, rd_count=0. Buffered words are lost; fifo_flops is also reset, so pndng=0.
- Counter wrap: cnt_w=4, 17 words streamed -> rd_count sequence reaches 15 then 0, ending at 1. All 17 words are delivered intact.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared types for the fifo_flops read-side consumer.
//   occ_t      : occupancy of the 2-entry output buffer (EMPTY/ONE/TWO)
//   OCC_W      : encoding width of occ_t
//   occ_space  : true while the buffer can accept another word
// The word type is logic [bits-1:0] and is declared in each module,
// because a package cannot take the module parameter bits.
package fifo_rd_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [OCC_W-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  function automatic logic occ_space(input occ_t occ);
    return occ != TWO;
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// 2-entry output buffer with occupancy FSM.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   push, din    : write din into the buffer tail (caller guarantees space)
//   valid, dout  : head entry presented downstream
//   ready        : downstream accepts the head this cycle
//   space        : buffer has a free slot (depends on registered state only)
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int bits = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [bits-1:0] din,
  output logic            valid,
  output logic [bits-1:0] dout,
  input  logic            ready,
  output logic            space
);

  occ_t            occ;
  logic [bits-1:0] e0, e1;   // e0 is the head, e1 the second entry
  logic            fire;

  assign valid = (occ != EMPTY);
  assign dout  = e0;
  assign space = occ_space(occ);
  assign fire  = valid && ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= EMPTY;
      e0  <= '0;
      e1  <= '0;
    end else begin
      case (occ)
        EMPTY: if (push) begin
          e0  <= din;
          occ <= ONE;
        end
        ONE: begin
          case ({push, fire})
            2'b10: begin e1 <= din; occ <= TWO;   end
            2'b01: begin            occ <= EMPTY; end
            // Head leaves while the incoming word takes its place.
            2'b11: begin e0 <= din; occ <= ONE;   end
            default: ;
          endcase
        end
        TWO: if (fire) begin
          e0  <= e1;
          occ <= ONE;
        end
        default: occ <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/fifo_flops_reader.sv
// Read-side consumer for fifo_flops: pops the first-word-fall-through FIFO
// into a 2-entry buffer and re-presents words on a valid/ready stream.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   pndng, fifo_dout     : FIFO not-empty flag and head word
//   pop                  : pop strobe to the FIFO
//   enable               : drain enable (gates new pops only)
//   out_data, out_valid  : downstream stream head
//   out_ready            : downstream accept
//   rd_count             : pops since reset, modulo 2^cnt_w
module fifo_flops_reader
  import fifo_rd_pkg::*;
#(
  parameter int bits  = 16,
  parameter int cnt_w = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pndng,
  input  logic [bits-1:0]  fifo_dout,
  output logic             pop,
  input  logic             enable,
  output logic [bits-1:0]  out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [cnt_w-1:0] rd_count
);

  logic space;

  // space comes from registered occupancy only, so out_ready never
  // reaches pop combinationally.
  assign pop = !rst && enable && pndng && space;

  fifo_rd_skid #(.bits(bits)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (pop),
    .din   (fifo_dout),
    .valid (out_valid),
    .dout  (out_data),
    .ready (out_ready),
    .space (space)
  );

  always_ff @(posedge clk) begin
    if (rst)      rd_count <= '0;
    else if (pop) rd_count <= rd_count + 1'b1;
  end

endmodule

// File: tb/tb_fifo_flops_reader.sv
module tb_fifo_flops_reader;
  localparam int BITS = 16;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            rst, pndng, pop, enable, out_valid, out_ready;
  logic [BITS-1:0] fifo_dout, out_data;
  logic [CW-1:0]   rd_count;

  fifo_flops_reader #(.bits(BITS), .cnt_w(CW)) dut (
    .clk(clk), .rst(rst), .pndng(pndng), .fifo_dout(fifo_dout), .pop(pop),
    .enable(enable), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  // Model: fq = words in fifo_flops, mb = words held by the reader,
  // dl = words delivered downstream, mcnt = pops since reset.
  logic [BITS-1:0] fq[$], mb[$], dl[$];
  int mcnt = 0, nchk = 0, nerr = 0, ppops = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: present FIFO state, compare outputs, advance model.
  task automatic cyc();
    bit ep, fire;
    pndng     = fq.size() > 0;
    fifo_dout = pndng ? fq[0] : 16'($urandom);
    #1;
    ep = !rst && enable && pndng && (mb.size() < 2);
    chk("pop", {31'd0, pop}, {31'd0, ep});
    chk("out_valid", {31'd0, out_valid}, {31'd0, mb.size() > 0});
    if (mb.size() > 0) chk("out_data", 32'(out_data), 32'(mb[0]));
    chk("rd_count", 32'(rd_count), 32'(mcnt));
    if (rst) begin
      mb.delete(); fq.delete(); mcnt = 0;
    end else begin
      fire = (mb.size() > 0) && out_ready;
      if (fire) dl.push_back(mb.pop_front());
      if (ep) begin
        mb.push_back(fq.pop_front());
        mcnt = (mcnt + 1) % (1 << CW);
        ppops++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((fq.size() > 0 || mb.size() > 0) && n < maxc) begin cyc(); n++; end
    if (n >= maxc) begin
      nchk++; nerr++;
      $display("FAIL drain_timeout: got %0d cycles want < %0d", n, maxc);
    end
  endtask

  task automatic phase_start();
    dl.delete(); ppops = 0;
  endtask

  initial begin
    logic [BITS-1:0] bp[3];
    bp[0] = 16'hA5A5; bp[1] = 16'h5A5A; bp[2] = 16'hFFFF;
    rst = 1; enable = 0; out_ready = 0; pndng = 0; fifo_dout = '0;
    @(negedge clk);

    // Reset and idle
    repeat (3) cyc();
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_rd_count", 32'(rd_count), 32'h0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'h0);
    rst = 0;
    repeat (2) cyc();
    chk("idle_valid", {31'd0, out_valid}, 32'h0);

    // Streaming 1..8
    phase_start();
    for (int i = 1; i <= 8; i++) fq.push_back(16'(i));
    enable = 1; out_ready = 1;
    repeat (8) cyc();
    chk("stream_pops8", 32'(ppops), 32'd8);
    drain(20);
    chk("stream_cnt", 32'(dl.size()), 32'd8);
    for (int i = 0; i < dl.size(); i++) chk("stream_word", 32'(dl[i]), 32'(i + 1));
    chk("stream_rd_count", 32'(rd_count), 32'd8);

    // Backpressure
    phase_start();
    for (int i = 0; i < 3; i++) fq.push_back(bp[i]);
    out_ready = 0;
    repeat (5) cyc();
    chk("bp_pops", 32'(ppops), 32'd2);
    chk("bp_pop_low", {31'd0, pop}, 32'h0);
    chk("bp_head", 32'(out_data), 32'hA5A5);
    out_ready = 1;
    drain(20);
    chk("bp_cnt", 32'(dl.size()), 32'd3);
    for (int i = 0; i < dl.size() && i < 3; i++) chk("bp_word", 32'(dl[i]), 32'(bp[i]));
    chk("bp_rd_count", 32'(rd_count), 32'd11);

    // Enable gating
    phase_start();
    for (int i = 0; i < 4; i++) fq.push_back(16'h1110 + 16'(i));
    out_ready = 0;
    repeat (2) cyc();
    enable = 0; out_ready = 1;
    repeat (4) cyc();
    chk("gate_pops", 32'(ppops), 32'd2);
    chk("gate_drained", 32'(dl.size()), 32'd2);
    chk("gate_rd_count", 32'(rd_count), 32'd13);
    enable = 1;
    drain(20);
    for (int i = 0; i < dl.size(); i++) chk("gate_word", 32'(dl[i]), 32'h1110 + 32'(i));
    chk("gate_rd_count2", 32'(rd_count), 32'd15);

    // Reset mid-stream with buffer full
    phase_start();
    for (int i = 0; i < 3; i++) fq.push_back(16'hC000 + 16'(i));
    out_ready = 0;
    repeat (2) cyc();
    rst = 1;
    cyc();
    chk("midrst_valid", {31'd0, out_valid}, 32'h0);
    chk("midrst_rd_count", 32'(rd_count), 32'h0);
    rst = 0;
    cyc();
    chk("midrst_pndng", {31'd0, pndng}, 32'h0);

    // Counter wrap: 17 words with a 4-bit counter
    phase_start();
    out_ready = 1; enable = 1;
    for (int i = 0; i < 17; i++) fq.push_back(16'h7700 + 16'(i));
    drain(40);
    chk("wrap_rd_count", 32'(rd_count), 32'd1);
    chk("wrap_cnt", 32'(dl.size()), 32'd17);
    for (int i = 0; i < dl.size(); i++) chk("wrap_word", 32'(dl[i]), 32'h7700 + 32'(i));

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if (fq.size() < 8 && $urandom_range(0, 1) == 1) fq.push_back(16'($urandom));
      enable    = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      rst       = $urandom_range(0, 99) == 0;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
